// File: rtl/multicycle_ctrl_fsm_pkg.sv
// Opcode constants, state and mux-select encodings shared by the multi-cycle control sequencer.
package multicycle_ctrl_fsm_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_I_ALU  = 7'b0010011;
    localparam logic [6:0] OP_R_TYPE = 7'b0110011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        ST_FETCH,
        ST_DECODE,
        ST_MEM_ADDR,
        ST_MEM_READ,
        ST_MEM_WB,
        ST_MEM_WRITE,
        ST_EXEC_R,
        ST_EXEC_I,
        ST_ALU_WB,
        ST_JAL,
        ST_JALR,
        ST_BRANCH,
        ST_UPPER,
        ST_FAULT
    } ctrl_state_e;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_J = 3'd3,
        IMM_U = 3'd4
    } imm_type_e;

    typedef enum logic [1:0] {
        A_PC     = 2'd0,
        A_OLD_PC = 2'd1,
        A_RS1    = 2'd2
    } alu_a_sel_e;

    typedef enum logic [1:0] {
        B_RS2  = 2'd0,
        B_IMM  = 2'd1,
        B_FOUR = 2'd2
    } alu_b_sel_e;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'd0,
        ALU_SUB   = 2'd1,
        ALU_FUNCT = 2'd2
    } alu_op_e;

    typedef enum logic [1:0] {
        RES_ALU_OUT    = 2'd0,
        RES_MEM_DATA   = 2'd1,
        RES_ALU_DIRECT = 2'd2
    } result_sel_e;

    function automatic imm_type_e imm_type_of(input logic [6:0] op);
        imm_type_e t;
        case (op)
            OP_STORE:         t = IMM_S;
            OP_BRANCH:        t = IMM_B;
            OP_JAL:           t = IMM_J;
            OP_LUI, OP_AUIPC: t = IMM_U;
            default:          t = IMM_I;
        endcase
        return t;
    endfunction

    // Unknown opcodes land in ST_FAULT, which is terminal until reset.
    function automatic ctrl_state_e decode_next(input logic [6:0] op);
        ctrl_state_e s;
        case (op)
            OP_LOAD, OP_STORE: s = ST_MEM_ADDR;
            OP_R_TYPE:         s = ST_EXEC_R;
            OP_I_ALU:          s = ST_EXEC_I;
            OP_JAL:            s = ST_JAL;
            OP_JALR:           s = ST_JALR;
            OP_BRANCH:         s = ST_BRANCH;
            OP_LUI, OP_AUIPC:  s = ST_UPPER;
            default:           s = ST_FAULT;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm_mem_timeout_counter.sv
// Counts consecutive cycles a memory request waits for ready; flags expiry on the limit-th wait cycle.
module multicycle_ctrl_fsm_mem_timeout_counter #(
    parameter int TMO_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             i_clear,
    input  logic             i_enable,
    input  logic [TMO_W-1:0] i_limit,
    output logic             o_expired
);

    logic [TMO_W-1:0] r_count;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + 1'b1;
        end
    end

    // A zero limit disables expiry entirely.
    assign o_expired = i_enable && (i_limit != '0) && (r_count == i_limit - 1'b1);

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle RISC-V control sequencer (FETCH/DECODE/EXECUTE/MEM/WB) with memory-wait timeout.
// Optional performance counters are built when CTRL_PERF_CNT_EN is defined.
module multicycle_ctrl_fsm
    import multicycle_ctrl_fsm_pkg::*;
#(
    parameter int MEM_TIMEOUT_CYCLES = 255,
    parameter int TMO_W              = 8
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [6:0]  op_code_i,
    input  logic        mem_ready_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic        addr_sel_o,
    output logic        ir_we_o,
    output logic        pc_we_o,
    output logic        branch_o,
    output logic        reg_we_o,
    output logic [1:0]  alu_a_sel_o,
    output logic [1:0]  alu_b_sel_o,
    output logic [1:0]  alu_op_o,
    output logic [1:0]  result_sel_o,
    output logic [2:0]  imm_type_o,
    output logic        retire_o,
    output logic        fault_o
`ifdef CTRL_PERF_CNT_EN
    ,
    output logic [31:0] cycle_cnt_o,
    output logic [31:0] instret_cnt_o
`endif
);

    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(MEM_TIMEOUT_CYCLES);

    ctrl_state_e r_state;
    logic        w_wait;
    logic        w_tmo_en;
    logic        w_expired;

    assign w_wait   = (r_state == ST_FETCH) || (r_state == ST_MEM_READ) || (r_state == ST_MEM_WRITE);
    assign w_tmo_en = w_wait && !mem_ready_i;

    multicycle_ctrl_fsm_mem_timeout_counter #(
        .TMO_W (TMO_W)
    ) u_tmo (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .i_clear   (!w_tmo_en),
        .i_enable  (w_tmo_en),
        .i_limit   (TMO_LIMIT),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_FETCH;
        end else begin
            case (r_state)
                ST_FETCH: begin
                    if (mem_ready_i)    r_state <= ST_DECODE;
                    else if (w_expired) r_state <= ST_FAULT;
                end
                ST_DECODE:   r_state <= decode_next(op_code_i);
                ST_MEM_ADDR: r_state <= op_code_i[5] ? ST_MEM_WRITE : ST_MEM_READ;
                ST_MEM_READ: begin
                    if (mem_ready_i)    r_state <= ST_MEM_WB;
                    else if (w_expired) r_state <= ST_FAULT;
                end
                ST_MEM_WRITE: begin
                    if (mem_ready_i)    r_state <= ST_FETCH;
                    else if (w_expired) r_state <= ST_FAULT;
                end
                ST_EXEC_R, ST_EXEC_I: r_state <= ST_ALU_WB;
                ST_MEM_WB, ST_ALU_WB, ST_JAL, ST_JALR, ST_BRANCH, ST_UPPER: r_state <= ST_FETCH;
                ST_FAULT:    r_state <= ST_FAULT;
                default:     r_state <= ST_FAULT;
            endcase
        end
    end

    // Outputs are held low while reset is asserted so an in-flight request drops at once.
    always_comb begin
        mem_req_o    = 1'b0;
        mem_we_o     = 1'b0;
        addr_sel_o   = 1'b0;
        ir_we_o      = 1'b0;
        pc_we_o      = 1'b0;
        branch_o     = 1'b0;
        reg_we_o     = 1'b0;
        alu_a_sel_o  = A_PC;
        alu_b_sel_o  = B_RS2;
        alu_op_o     = ALU_ADD;
        result_sel_o = RES_ALU_OUT;
        imm_type_o   = IMM_I;
        retire_o     = 1'b0;
        fault_o      = 1'b0;
        if (rst_ni) begin
            imm_type_o = imm_type_of(op_code_i);
            case (r_state)
                ST_FETCH: begin
                    mem_req_o = 1'b1;
                    if (mem_ready_i) begin
                        ir_we_o     = 1'b1;
                        pc_we_o     = 1'b1;
                        alu_a_sel_o = A_PC;
                        alu_b_sel_o = B_FOUR;
                        alu_op_o    = ALU_ADD;
                    end
                end
                ST_DECODE: begin
                    alu_a_sel_o = A_OLD_PC;
                    alu_b_sel_o = B_IMM;
                end
                ST_MEM_ADDR: begin
                    alu_a_sel_o = A_RS1;
                    alu_b_sel_o = B_IMM;
                end
                ST_MEM_READ: begin
                    mem_req_o  = 1'b1;
                    addr_sel_o = 1'b1;
                end
                ST_MEM_WB: begin
                    reg_we_o     = 1'b1;
                    result_sel_o = RES_MEM_DATA;
                    retire_o     = 1'b1;
                end
                ST_MEM_WRITE: begin
                    mem_req_o  = 1'b1;
                    mem_we_o   = 1'b1;
                    addr_sel_o = 1'b1;
                    retire_o   = mem_ready_i;
                end
                ST_EXEC_R: begin
                    alu_a_sel_o = A_RS1;
                    alu_b_sel_o = B_RS2;
                    alu_op_o    = ALU_FUNCT;
                end
                ST_EXEC_I: begin
                    alu_a_sel_o = A_RS1;
                    alu_b_sel_o = B_IMM;
                    alu_op_o    = ALU_FUNCT;
                end
                ST_ALU_WB: begin
                    reg_we_o = 1'b1;
                    retire_o = 1'b1;
                end
                // Target was precomputed in DECODE and sits in the ALU result register.
                ST_JAL: begin
                    pc_we_o     = 1'b1;
                    reg_we_o    = 1'b1;
                    alu_a_sel_o = A_PC;
                    alu_b_sel_o = B_FOUR;
                    retire_o    = 1'b1;
                end
                ST_JALR: begin
                    alu_a_sel_o = A_RS1;
                    alu_b_sel_o = B_IMM;
                    pc_we_o     = 1'b1;
                    reg_we_o    = 1'b1;
                    retire_o    = 1'b1;
                end
                ST_BRANCH: begin
                    alu_a_sel_o = A_RS1;
                    alu_b_sel_o = B_RS2;
                    alu_op_o    = ALU_SUB;
                    branch_o    = 1'b1;
                    retire_o    = 1'b1;
                end
                ST_UPPER: begin
                    alu_a_sel_o  = op_code_i[5] ? A_RS1 : A_OLD_PC;
                    alu_b_sel_o  = B_IMM;
                    reg_we_o     = 1'b1;
                    result_sel_o = RES_ALU_DIRECT;
                    retire_o     = 1'b1;
                end
                ST_FAULT: fault_o = 1'b1;
                default:  fault_o = 1'b1;
            endcase
        end
    end

`ifdef CTRL_PERF_CNT_EN
    logic [31:0] r_cycle_cnt;
    logic [31:0] r_instret_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cycle_cnt   <= '0;
            r_instret_cnt <= '0;
        end else if (r_state != ST_FAULT) begin
            r_cycle_cnt <= r_cycle_cnt + 32'd1;
            if (retire_o) r_instret_cnt <= r_instret_cnt + 32'd1;
        end
    end

    assign cycle_cnt_o   = r_cycle_cnt;
    assign instret_cnt_o = r_instret_cnt;
`endif

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed self-checking bench for multicycle_ctrl_fsm (timeout limit set to 4 cycles).
module tb_multicycle_ctrl_fsm;

    logic        clk_i;
    logic        rst_ni;
    logic [6:0]  op_code_i;
    logic        mem_ready_i;
    logic        mem_req_o, mem_we_o, addr_sel_o, ir_we_o, pc_we_o, branch_o, reg_we_o;
    logic [1:0]  alu_a_sel_o, alu_b_sel_o, alu_op_o, result_sel_o;
    logic [2:0]  imm_type_o;
    logic        retire_o, fault_o;
`ifdef CTRL_PERF_CNT_EN
    logic [31:0] cycle_cnt_o, instret_cnt_o;
`endif

    int numChecks = 0;
    int numErrors = 0;

    logic [19:0] obsVec;
    assign obsVec = {mem_req_o, mem_we_o, addr_sel_o, ir_we_o, pc_we_o, branch_o, reg_we_o,
                     alu_a_sel_o, alu_b_sel_o, alu_op_o, result_sel_o, imm_type_o, retire_o, fault_o};

    multicycle_ctrl_fsm #(
        .MEM_TIMEOUT_CYCLES (4),
        .TMO_W              (8)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .op_code_i     (op_code_i),
        .mem_ready_i   (mem_ready_i),
        .mem_req_o     (mem_req_o),
        .mem_we_o      (mem_we_o),
        .addr_sel_o    (addr_sel_o),
        .ir_we_o       (ir_we_o),
        .pc_we_o       (pc_we_o),
        .branch_o      (branch_o),
        .reg_we_o      (reg_we_o),
        .alu_a_sel_o   (alu_a_sel_o),
        .alu_b_sel_o   (alu_b_sel_o),
        .alu_op_o      (alu_op_o),
        .result_sel_o  (result_sel_o),
        .imm_type_o    (imm_type_o),
        .retire_o      (retire_o),
        .fault_o       (fault_o)
`ifdef CTRL_PERF_CNT_EN
        ,
        .cycle_cnt_o   (cycle_cnt_o),
        .instret_cnt_o (instret_cnt_o)
`endif
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // ctrl = {req, we, addr_sel, ir_we, pc_we, branch, reg_we}
    function automatic logic [19:0] ev(input logic [6:0] ctrl, input logic [1:0] a, input logic [1:0] b,
                                       input logic [1:0] op, input logic [1:0] res, input logic [2:0] imm,
                                       input logic ret, input logic flt);
        return {ctrl, a, b, op, res, imm, ret, flt};
    endfunction

    function automatic logic [19:0] fetchRdy(input logic [2:0] imm);
        return ev(7'b1001100, 2'd0, 2'd2, 2'd0, 2'd0, imm, 1'b0, 1'b0);
    endfunction

    function automatic logic [19:0] fetchWait(input logic [2:0] imm);
        return ev(7'b1000000, 2'd0, 2'd0, 2'd0, 2'd0, imm, 1'b0, 1'b0);
    endfunction

    function automatic logic [19:0] decodeVec(input logic [2:0] imm);
        return ev(7'b0000000, 2'd1, 2'd1, 2'd0, 2'd0, imm, 1'b0, 1'b0);
    endfunction

    function automatic logic [19:0] faultVec(input logic [2:0] imm);
        return ev(7'b0000000, 2'd0, 2'd0, 2'd0, 2'd0, imm, 1'b0, 1'b1);
    endfunction

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Leaves the bench one time unit after the edge that starts cycle 1 out of reset.
    task automatic applyReset(input logic [6:0] op);
        rst_ni      = 1'b0;
        op_code_i   = op;
        mem_ready_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
    endtask

    task automatic test_reset();
        rst_ni      = 1'b0;
        op_code_i   = 7'h13;
        mem_ready_i = 1'b1;
        #3;
        numChecks++;
        if (obsVec !== 20'h0) begin
            numErrors++;
            $display("[TB] FAIL reset_ready_hi got %h want %h", obsVec, 20'h0);
        end
        mem_ready_i = 1'b0;
        #1;
        numChecks++;
        if (obsVec !== 20'h0) begin
            numErrors++;
            $display("[TB] FAIL reset_ready_lo got %h want %h", obsVec, 20'h0);
        end
    endtask

    task automatic test_addi();
        logic [19:0] expV [5];
        expV[0] = fetchRdy(3'd0);
        expV[1] = decodeVec(3'd0);
        expV[2] = ev(7'b0000000, 2'd2, 2'd1, 2'd2, 2'd0, 3'd0, 1'b0, 1'b0);
        expV[3] = ev(7'b0000001, 2'd0, 2'd0, 2'd0, 2'd0, 3'd0, 1'b1, 1'b0);
        expV[4] = fetchRdy(3'd0);
        applyReset(7'h13);
        for (int c = 0; c < 5; c++) begin
            mem_ready_i = 1'b1;
            #1;
            numChecks++;
            if (obsVec !== expV[c]) begin
                numErrors++;
                $display("[TB] FAIL addi_cycle%0d got %h want %h", c + 1, obsVec, expV[c]);
            end
            step();
        end
    endtask

    task automatic test_lw();
        logic [19:0] expV [9];
        logic        rdy  [9];
        rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        expV[0] = fetchRdy(3'd0);
        expV[1] = decodeVec(3'd0);
        expV[2] = ev(7'b0000000, 2'd2, 2'd1, 2'd0, 2'd0, 3'd0, 1'b0, 1'b0);
        for (int i = 3; i < 7; i++) expV[i] = ev(7'b1010000, 2'd0, 2'd0, 2'd0, 2'd0, 3'd0, 1'b0, 1'b0);
        expV[7] = ev(7'b0000001, 2'd0, 2'd0, 2'd0, 2'd1, 3'd0, 1'b1, 1'b0);
        expV[8] = fetchWait(3'd0);
        applyReset(7'h03);
        for (int c = 0; c < 9; c++) begin
            mem_ready_i = rdy[c];
            #1;
            numChecks++;
            if (obsVec !== expV[c]) begin
                numErrors++;
                $display("[TB] FAIL lw_cycle%0d got %h want %h", c + 1, obsVec, expV[c]);
            end
            step();
        end
    endtask

    task automatic test_sw();
        logic [19:0] expV [6];
        logic        rdy  [6];
        rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        expV[0] = fetchRdy(3'd1);
        expV[1] = decodeVec(3'd1);
        expV[2] = ev(7'b0000000, 2'd2, 2'd1, 2'd0, 2'd0, 3'd1, 1'b0, 1'b0);
        expV[3] = ev(7'b1110000, 2'd0, 2'd0, 2'd0, 2'd0, 3'd1, 1'b0, 1'b0);
        expV[4] = ev(7'b1110000, 2'd0, 2'd0, 2'd0, 2'd0, 3'd1, 1'b1, 1'b0);
        expV[5] = fetchWait(3'd1);
        applyReset(7'h23);
        for (int c = 0; c < 6; c++) begin
            mem_ready_i = rdy[c];
            #1;
            numChecks++;
            if (obsVec !== expV[c]) begin
                numErrors++;
                $display("[TB] FAIL sw_cycle%0d got %h want %h", c + 1, obsVec, expV[c]);
            end
            step();
        end
    endtask

    // Branch, JAL, JALR, LUI, AUIPC and R-type: cycles 1..4 from reset with ready held high.
    task automatic test_control_flow();
        logic [6:0]  ops  [6];
        logic [2:0]  imms [6];
        logic [19:0] exp3 [6];
        logic [19:0] exp4 [6];
        logic [19:0] expV;
        ops  = '{7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h33};
        imms = '{3'd2, 3'd3, 3'd0, 3'd4, 3'd4, 3'd0};
        exp3[0] = ev(7'b0000010, 2'd2, 2'd0, 2'd1, 2'd0, 3'd2, 1'b1, 1'b0);
        exp3[1] = ev(7'b0000101, 2'd0, 2'd2, 2'd0, 2'd0, 3'd3, 1'b1, 1'b0);
        exp3[2] = ev(7'b0000101, 2'd2, 2'd1, 2'd0, 2'd0, 3'd0, 1'b1, 1'b0);
        exp3[3] = ev(7'b0000001, 2'd2, 2'd1, 2'd0, 2'd2, 3'd4, 1'b1, 1'b0);
        exp3[4] = ev(7'b0000001, 2'd1, 2'd1, 2'd0, 2'd2, 3'd4, 1'b1, 1'b0);
        exp3[5] = ev(7'b0000000, 2'd2, 2'd0, 2'd2, 2'd0, 3'd0, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) exp4[k] = fetchRdy(imms[k]);
        exp4[5] = ev(7'b0000001, 2'd0, 2'd0, 2'd0, 2'd0, 3'd0, 1'b1, 1'b0);
        for (int k = 0; k < 6; k++) begin
            applyReset(ops[k]);
            for (int c = 0; c < 4; c++) begin
                mem_ready_i = 1'b1;
                #1;
                case (c)
                    0:       expV = fetchRdy(imms[k]);
                    1:       expV = decodeVec(imms[k]);
                    2:       expV = exp3[k];
                    default: expV = exp4[k];
                endcase
                numChecks++;
                if (obsVec !== expV) begin
                    numErrors++;
                    $display("[TB] FAIL flow_op%h_cycle%0d got %h want %h", ops[k], c + 1, obsVec, expV);
                end
                step();
            end
        end
    endtask

    task automatic test_illegal_opcode();
        logic [19:0] expV [3];
        expV[0] = fetchRdy(3'd0);
        expV[1] = decodeVec(3'd0);
        expV[2] = faultVec(3'd0);
        applyReset(7'h7F);
        for (int c = 0; c < 3; c++) begin
            mem_ready_i = 1'b1;
            #1;
            numChecks++;
            if (obsVec !== expV[c]) begin
                numErrors++;
                $display("[TB] FAIL illegal_cycle%0d got %h want %h", c + 1, obsVec, expV[c]);
            end
            step();
        end
        for (int c = 0; c < 100; c++) begin
            mem_ready_i = c[0];
            #1;
            numChecks++;
            if (obsVec !== faultVec(3'd0)) begin
                numErrors++;
                $display("[TB] FAIL illegal_hold%0d got %h want %h", c, obsVec, faultVec(3'd0));
            end
            step();
        end
        rst_ni = 1'b0;
        #1;
        numChecks++;
        if (obsVec !== 20'h0) begin
            numErrors++;
            $display("[TB] FAIL illegal_reset got %h want %h", obsVec, 20'h0);
        end
        @(posedge clk_i);
        #1;
        rst_ni      = 1'b1;
        mem_ready_i = 1'b0;
        #1;
        numChecks++;
        if (obsVec !== fetchWait(3'd0)) begin
            numErrors++;
            $display("[TB] FAIL illegal_recover got %h want %h", obsVec, fetchWait(3'd0));
        end
    endtask

    task automatic test_timeout();
        logic [19:0] expV [6];
        for (int i = 0; i < 4; i++) expV[i] = fetchWait(3'd0);
        expV[4] = faultVec(3'd0);
        expV[5] = faultVec(3'd0);
        applyReset(7'h13);
        for (int c = 0; c < 6; c++) begin
            mem_ready_i = 1'b0;
            #1;
            numChecks++;
            if (obsVec !== expV[c]) begin
                numErrors++;
                $display("[TB] FAIL timeout_cycle%0d got %h want %h", c + 1, obsVec, expV[c]);
            end
            step();
        end
    endtask

    task automatic test_ready_at_limit();
        logic [19:0] expV [6];
        logic        rdy  [6];
        rdy = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 3; i++) expV[i] = fetchWait(3'd0);
        expV[3] = fetchRdy(3'd0);
        expV[4] = decodeVec(3'd0);
        expV[5] = ev(7'b0000000, 2'd2, 2'd1, 2'd2, 2'd0, 3'd0, 1'b0, 1'b0);
        applyReset(7'h13);
        for (int c = 0; c < 6; c++) begin
            mem_ready_i = rdy[c];
            #1;
            numChecks++;
            if (obsVec !== expV[c]) begin
                numErrors++;
                $display("[TB] FAIL limit_race_cycle%0d got %h want %h", c + 1, obsVec, expV[c]);
            end
            step();
        end
    endtask

    task automatic test_mid_reset();
        logic [19:0] readVec;
        readVec = ev(7'b1010000, 2'd0, 2'd0, 2'd0, 2'd0, 3'd0, 1'b0, 1'b0);
        applyReset(7'h03);
        mem_ready_i = 1'b1;
        repeat (3) step();
        mem_ready_i = 1'b0;
        #1;
        numChecks++;
        if (obsVec !== readVec) begin
            numErrors++;
            $display("[TB] FAIL midreset_memread got %h want %h", obsVec, readVec);
        end
        mem_ready_i = 1'b1;
        #1;
        rst_ni = 1'b0;
        #1;
        numChecks++;
        if (obsVec !== 20'h0) begin
            numErrors++;
            $display("[TB] FAIL midreset_drop got %h want %h", obsVec, 20'h0);
        end
        @(posedge clk_i);
        #1;
        rst_ni      = 1'b1;
        mem_ready_i = 1'b0;
        #1;
        numChecks++;
        if (obsVec !== fetchWait(3'd0)) begin
            numErrors++;
            $display("[TB] FAIL midreset_fetch got %h want %h", obsVec, fetchWait(3'd0));
        end
    endtask

    task automatic test_back_to_back();
        logic expRet;
        applyReset(7'h13);
        for (int c = 0; c < 12; c++) begin
            mem_ready_i = 1'b1;
            #1;
            expRet = ((c % 4) == 3);
            numChecks++;
            if (retire_o !== expRet) begin
                numErrors++;
                $display("[TB] FAIL b2b_retire_cycle%0d got %b want %b", c + 1, retire_o, expRet);
            end
            step();
        end
`ifdef CTRL_PERF_CNT_EN
        numChecks++;
        if (cycle_cnt_o !== 32'd12) begin
            numErrors++;
            $display("[TB] FAIL b2b_cycle_cnt got %0d want %0d", cycle_cnt_o, 12);
        end
        numChecks++;
        if (instret_cnt_o !== 32'd3) begin
            numErrors++;
            $display("[TB] FAIL b2b_instret_cnt got %0d want %0d", instret_cnt_o, 3);
        end
`endif
    endtask

    initial begin
        rst_ni      = 1'b0;
        op_code_i   = 7'h00;
        mem_ready_i = 1'b0;
        test_reset();
        test_addi();
        test_lw();
        test_sw();
        test_control_flow();
        test_illegal_opcode();
        test_timeout();
        test_ready_at_limit();
        test_mid_reset();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", numChecks, numErrors);
        $finish;
    end

endmodule
